varredura_teclado: RTL and testbench



---
 rtl/varredura_pkg.sv | 29 ++
 rtl/sincronizador_2ff.sv | 26 ++
 rtl/varredura_teclado.sv | 153 +++++++++++++++
 tb/tb_varredura_teclado.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared defaults, width helpers and the lowest-set-index function for the keypad matrix scanner.
package varredura_pkg;

    localparam int N_LIN_PADRAO         = 2;
    localparam int N_COL_PADRAO         = 4;
    localparam int SCAN_DIV_PADRAO      = 1000;
    localparam int DEB_AMOSTRAS_PADRAO  = 3;
    localparam int REPEAT_FRAMES_PADRAO = 50;

    // Widest key vector menor_indice accepts; larger matrices must raise this.
    localparam int MAX_TECLAS = 64;

    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CODIGO_W_PADRAO = largura(N_LIN_PADRAO * N_COL_PADRAO);
    localparam int LINHA_W_PADRAO  = largura(N_LIN_PADRAO);

    function automatic int menor_indice(input logic [MAX_TECLAS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_TECLAS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for the asynchronous column returns, with asynchronous active-low clear.
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sinc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sinc <= '0;
        end else begin
            r_meta <= i_d;
            r_sinc <= r_meta;
        end
    end

    assign o_q = r_sinc;

endmodule

// File: rtl/varredura_teclado.sv
// Row/column push-button matrix scanner with whole-frame debounce and press events.
// Define VARREDURA_TECLADO_REPETICAO_EN to add auto-repeat pulses for a single held key.
module varredura_teclado
    import varredura_pkg::*;
#(
    parameter int N_LIN         = N_LIN_PADRAO,
    parameter int N_COL         = N_COL_PADRAO,
    parameter int SCAN_DIV      = SCAN_DIV_PADRAO,
    parameter int DEB_AMOSTRAS  = DEB_AMOSTRAS_PADRAO,
    parameter int REPEAT_FRAMES = REPEAT_FRAMES_PADRAO
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_COL-1:0]                   colunas_in,
    output logic [N_LIN-1:0]                   linhas_scan,
    output logic [N_LIN*N_COL-1:0]             botoes,
    output logic                               pressionado,
    output logic [largura(N_LIN*N_COL)-1:0]    codigo,
    output logic [largura(N_LIN)-1:0]          db_linha
);

    localparam int N_TECLAS = N_LIN * N_COL;
    localparam int CODIGO_W = largura(N_TECLAS);
    localparam int LINHA_W  = largura(N_LIN);
    localparam int DIV_W    = largura(SCAN_DIV);
    localparam int CNT_W    = largura(DEB_AMOSTRAS + 1);

    logic [N_COL-1:0]    w_col_sinc;
    logic [N_COL-1:0]    w_col;
    logic                w_fim_linha;
    logic [DIV_W-1:0]    r_div;
    logic [LINHA_W-1:0]  r_linha;
    logic [N_TECLAS-1:0] r_quadro;
    logic                r_quadro_ok;
    logic [N_TECLAS-1:0] r_anterior;
    logic [CNT_W-1:0]    r_estavel;
    logic [CNT_W-1:0]    w_estavel_prox;
    logic [N_TECLAS-1:0] r_botoes;
    logic [N_TECLAS-1:0] r_botoes_ant;
    logic [N_TECLAS-1:0] w_novos;
    logic                w_rep;
    logic                r_press;
    logic [CODIGO_W-1:0] r_codigo;

    sincronizador_2ff #(
        .W (N_COL)
    ) u_sinc (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_d     (colunas_in),
        .o_q     (w_col_sinc)
    );

    // Columns are pulled up; a closed contact reads as 0.
    assign w_col       = ~w_col_sinc;
    assign w_fim_linha = (r_div == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div       <= '0;
            r_linha     <= '0;
            r_quadro    <= '0;
            r_quadro_ok <= 1'b0;
        end else begin
            r_quadro_ok <= 1'b0;
            if (w_fim_linha) begin
                r_div <= '0;
                r_quadro[int'(r_linha)*N_COL +: N_COL] <= w_col;
                if (r_linha == LINHA_W'(N_LIN - 1)) begin
                    r_linha     <= '0;
                    r_quadro_ok <= 1'b1;
                end else begin
                    r_linha <= r_linha + LINHA_W'(1);
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_estavel_prox = CNT_W'(1);
        if (r_quadro == r_anterior) begin
            if (r_estavel >= CNT_W'(DEB_AMOSTRAS))
                w_estavel_prox = CNT_W'(DEB_AMOSTRAS);
            else
                w_estavel_prox = r_estavel + CNT_W'(1);
        end
    end

    // Whole-frame debounce, evaluated on the cycle after the last row is sampled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estavel  <= '0;
            r_anterior <= '0;
            r_botoes   <= '0;
        end else if (r_quadro_ok) begin
            r_estavel <= w_estavel_prox;
            if (r_quadro != r_anterior)
                r_anterior <= r_quadro;
            if (w_estavel_prox == CNT_W'(DEB_AMOSTRAS))
                r_botoes <= r_quadro;
        end
    end

    assign w_novos = r_botoes & ~r_botoes_ant;

`ifdef VARREDURA_TECLADO_REPETICAO_EN
    localparam int REP_W = largura(REPEAT_FRAMES + 1);

    logic [REP_W-1:0] r_rep;
    logic             w_rep_fim;

    assign w_rep_fim = (r_rep == REP_W'(REPEAT_FRAMES - 1));
    assign w_rep     = r_quadro_ok && w_rep_fim && $onehot(r_botoes) && (r_botoes == r_botoes_ant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rep <= '0;
        end else if ((r_botoes != r_botoes_ant) || !$onehot(r_botoes)) begin
            r_rep <= '0;
        end else if (r_quadro_ok) begin
            r_rep <= w_rep_fim ? '0 : r_rep + REP_W'(1);
        end
    end
`else
    // Keeps REPEAT_FRAMES referenced when auto-repeat is compiled out.
    assign w_rep = 1'b0 & (REPEAT_FRAMES > 0);
`endif

    // Only the lowest new key is reported; other simultaneous presses stay visible in botoes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_botoes_ant <= '0;
            r_press      <= 1'b0;
            r_codigo     <= '0;
        end else begin
            r_botoes_ant <= r_botoes;
            r_press      <= (|w_novos) | w_rep;
            if (|w_novos)
                r_codigo <= CODIGO_W'(menor_indice(MAX_TECLAS'(w_novos)));
            else if (w_rep)
                r_codigo <= CODIGO_W'(menor_indice(MAX_TECLAS'(r_botoes)));
        end
    end

    assign linhas_scan = ~(N_LIN'(1) << r_linha);
    assign botoes      = r_botoes;
    assign pressionado = r_press;
    assign codigo      = r_codigo;
    assign db_linha    = r_linha;

endmodule

// File: tb/tb_varredura_teclado.sv
// Scoreboard bench for varredura_teclado: 2x4 matrix, SCAN_DIV=4, DEB_AMOSTRAS=3 (8-clock frames).
module tb_varredura_teclado;

    logic       clock;
    logic       reset;
    logic [3:0] colunas_in;
    logic [1:0] linhas_scan;
    logic [7:0] botoes;
    logic       pressionado;
    logic [2:0] codigo;
    logic [0:0] db_linha;

    logic [7:0] teclas;
    logic [3:0] ruido;
    logic [2:0] fila[$];
    int         total;
    int         bad;

    varredura_teclado #(
        .N_LIN         (2),
        .N_COL         (4),
        .SCAN_DIV      (4),
        .DEB_AMOSTRAS  (3),
        .REPEAT_FRAMES (50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .colunas_in  (colunas_in),
        .linhas_scan (linhas_scan),
        .botoes      (botoes),
        .pressionado (pressionado),
        .codigo      (codigo),
        .db_linha    (db_linha)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Passive matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        colunas_in = 4'b1111;
        if (linhas_scan == 2'b10)
            colunas_in = ~teclas[3:0];
        else if (linhas_scan == 2'b01)
            colunas_in = ~teclas[7:4];
        colunas_in = colunas_in ^ ruido;
    end

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s atual=%0h esperado=%0h t=%0t", nome, atual, esperado, $time);
        end
    endtask

    // Monitor: every pressionado cycle must match the oldest expected key code.
    always @(negedge clock) begin
        logic [2:0] esp;
        if (reset && pressionado) begin
            total++;
            if (fila.size() == 0) begin
                bad++;
                $display("FAIL pulso_inesperado codigo=%0d esperado=nenhum t=%0t", codigo, $time);
            end else begin
                esp = fila.pop_front();
                if (codigo !== esp) begin
                    bad++;
                    $display("FAIL codigo_pulso atual=%0d esperado=%0d t=%0t", codigo, esp, $time);
                end
            end
        end
    end

    // Returns just after the edge on which row 1 is sampled and the scan wraps to row 0.
    task automatic alinhar_quadro();
        logic [0:0] ant;
        bit         ok;
        ok  = 1'b0;
        ant = db_linha;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ant == 1'b1 && db_linha == 1'b0) begin
                ok = 1'b1;
                break;
            end
            ant = db_linha;
        end
        chk("alinhamento", 32'(ok), 32'd1);
    endtask

    // New key state from a frame boundary: accepted exactly 25 clocks later (3 frames + 1).
    task automatic degrau(input string nome, input logic [7:0] novo, input logic [7:0] antigo);
        alinhar_quadro();
        teclas = novo;
        repeat (24) @(negedge clock);
        chk({nome, "_antes"}, 32'(botoes), 32'(antigo));
        @(negedge clock);
        chk({nome, "_aceito"}, 32'(botoes), 32'(novo));
    endtask

    task automatic esperar_botoes(input string nome, input logic [7:0] alvo, input int limite);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (botoes == alvo) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nome, 32'(ok), 32'd1);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        teclas = 8'h00;
        ruido  = 4'h0;

        repeat (3) @(negedge clock);
        chk("rst_linhas", 32'(linhas_scan), 32'h2);
        chk("rst_botoes", 32'(botoes), 32'h0);
        chk("rst_press", 32'(pressionado), 32'h0);
        chk("rst_codigo", 32'(codigo), 32'h0);
        chk("rst_db_linha", 32'(db_linha), 32'h0);
        reset = 1'b1;

        // Idle scan: row 0 for edges 0..3, row 1 for 4..7, and so on.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            chk("scan_linhas", 32'(linhas_scan), ((k / 4) % 2 == 0) ? 32'h2 : 32'h1);
            chk("scan_botoes", 32'(botoes), 32'h0);
        end

        // Single key 6 (row 1, column 2).
        fila.push_back(3'd6);
        degrau("tecla6", 8'h40, 8'h00);
        repeat (40) @(negedge clock);
        chk("tecla6_mantem", 32'(botoes), 32'h40);
        chk("codigo_retido", 32'(codigo), 32'd6);

        degrau("solta6", 8'h00, 8'h40);
        repeat (16) @(negedge clock);

        // Contact bounce: never three identical frames in a row.
        teclas = 8'h40;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) ruido = ruido ^ 4'b0100;
            @(negedge clock);
            chk("quique_botoes", 32'(botoes), 32'h0);
        end
        teclas = 8'h00;
        ruido  = 4'h0;
        repeat (8) @(negedge clock);
        fila.push_back(3'd6);
        degrau("pos_quique", 8'h40, 8'h00);
        repeat (16) @(negedge clock);

        degrau("solta_quique", 8'h00, 8'h40);
        repeat (16) @(negedge clock);

        // Keys 1 and 6 together: only the lowest index is reported.
        fila.push_back(3'd1);
        degrau("duas_teclas", 8'h42, 8'h00);
        repeat (16) @(negedge clock);

        degrau("solta_todas", 8'h00, 8'h42);
        repeat (16) @(negedge clock);

        // Asynchronous reset in the middle of a frame while key 6 is held.
        fila.push_back(3'd6);
        degrau("pre_reset", 8'h40, 8'h00);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_linhas", 32'(linhas_scan), 32'h2);
        chk("async_botoes", 32'(botoes), 32'h0);
        chk("async_press", 32'(pressionado), 32'h0);
        chk("async_codigo", 32'(codigo), 32'h0);
        chk("async_db_linha", 32'(db_linha), 32'h0);
        repeat (2) @(negedge clock);
        chk("reset_mantido", 32'(botoes), 32'h0);
        fila.push_back(3'd6);
        reset = 1'b1;
        esperar_botoes("redetecta6", 8'h40, 50);
        repeat (10) @(negedge clock);

        chk("fila_vazia", 32'(fila.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
